// File: rtl/prog_loader.sv
// Program loader: parses a framed host byte stream (SOF, LEN, 4*LEN data bytes, CSUM) into instruction memory, then runs the core until halt.
// Latency: each instruction word is written 1 cycle after its 4th byte handshake; cpu_rst_n rises 1 cycle after CSUM, cpu_en one cycle later.
// Backpressure: in_ready is high in every state except RUN, where host bytes are refused; a stalled frame waits indefinitely.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_data/in_ready - host byte stream (valid/ready handshake)
//   imem_we/imem_addr/imem_wdata - instruction memory write port (one-cycle strobe per word)
//   cpu_rst_n, cpu_en, cpu_halt  - core reset (active-low), pipeline enable, halt indication
//   busy, done, err          - frame in progress, program halted, sticky error (1 length, 2 checksum)
module prog_loader #(
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  SOF    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic              cpu_en,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  // 17 bits so that a 16-bit length can be compared against a full 2^16 capacity.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic [7:0]  len_hi;
  logic [15:0] wlen;     // word count N of the current frame
  logic [15:0] wcnt;     // words written so far
  logic [1:0]  bidx;     // byte position within the current word
  logic [23:0] asm_r;    // first three bytes of the word being assembled
  logic [7:0]  csum_r;   // running XOR of bytes after SOF

  logic        acc;
  logic [15:0] len_full;
  logic [31:0] word_full;

  assign acc       = in_valid & in_ready;
  assign len_full  = {len_hi, in_data};
  assign word_full = {asm_r, in_data};

  always_comb begin
    in_ready = (state != S_RUN);
    busy     = (state == S_LEN_HI) || (state == S_LEN_LO) ||
               (state == S_DATA)   || (state == S_CSUM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      len_hi     <= 8'd0;
      wlen       <= 16'd0;
      wcnt       <= 16'd0;
      bidx       <= 2'd0;
      asm_r      <= 24'd0;
      csum_r     <= 8'd0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
      cpu_rst_n  <= 1'b0;
      cpu_en     <= 1'b0;
      done       <= 1'b0;
      err        <= 2'd0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        // A new frame may start from idle or after a finished/failed one;
        // starting one always puts the core back into reset.
        S_IDLE, S_DONE, S_ERR: begin
          if (acc && (in_data == SOF)) begin
            state     <= S_LEN_HI;
            csum_r    <= 8'd0;
            err       <= 2'd0;
            done      <= 1'b0;
            cpu_rst_n <= 1'b0;
            cpu_en    <= 1'b0;
          end
        end

        S_LEN_HI: begin
          if (acc) begin
            len_hi <= in_data;
            csum_r <= csum_r ^ in_data;
            state  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (acc) begin
            csum_r <= csum_r ^ in_data;
            wlen   <= len_full;
            wcnt   <= 16'd0;
            bidx   <= 2'd0;
            if ({1'b0, len_full} > DEPTH) begin
              state <= S_ERR;
              err   <= 2'd1;
            end else if (len_full == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (acc) begin
            csum_r <= csum_r ^ in_data;
            asm_r  <= {asm_r[15:0], in_data};
            bidx   <= bidx + 2'd1;
            if (bidx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_addr  <= wcnt[ADDR_W-1:0];
              imem_wdata <= word_full;
              wcnt       <= wcnt + 16'd1;
              if (wcnt == (wlen - 16'd1)) begin
                state <= S_CSUM;
              end
            end
          end
        end

        S_CSUM: begin
          if (acc) begin
            if (in_data == csum_r) begin
              state     <= S_RUN;
              cpu_rst_n <= 1'b1;
            end else begin
              state     <= S_ERR;
              err       <= 2'd2;
              cpu_rst_n <= 1'b0;
              cpu_en    <= 1'b0;
            end
          end
        end

        // First RUN cycle keeps the pipeline disabled so the core sees one
        // reset-free cycle with en=0; halt takes priority over enabling.
        S_RUN: begin
          if (cpu_halt) begin
            state  <= S_DONE;
            cpu_en <= 1'b0;
            done   <= 1'b1;
          end else begin
            cpu_en <= 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_rst_n;
  logic              cpu_en;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic [1:0]        err;

  prog_loader #(.ADDR_W(ADDR_W), .SOF(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst_n  (cpu_rst_n),
    .cpu_en     (cpu_en),
    .cpu_halt   (cpu_halt),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [23:0] cyc;
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         got_q[$];
  wr_t         exp_q[$];
  logic [31:0] words[$];
  int          vectors     = 0;
  int          miscompares = 0;
  logic        prev_we     = 1'b0;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitor: records every strobe with the cycle it is visible in.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_q.push_back({24'(cyc), 16'(imem_addr), imem_wdata});
      vectors++;
      assert (prev_we !== 1'b1) else begin
        miscompares++;
        $error("FAIL we_b2b: observed 1 expected 0 at cycle %0d", cyc);
      end
    end
    prev_we = imem_we;
  end

  // Offer one byte (after an optional random idle gap); hs = cycle of the handshake.
  task automatic send_byte(input logic [7:0] b, input bit rgap, output int hs);
    int tmo;
    int g;
    g = rgap ? int'($urandom_range(0, 3)) : 0;
    repeat (g) @(negedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    tmo = 0;
    while (!in_ready && tmo < 50) begin
      @(negedge clk);
      tmo++;
    end
    chk("ready_wait", 96'(tmo < 50), 96'd1);
    @(posedge clk);
    #1;
    hs = cyc;
    in_valid = 1'b0;
  endtask

  // Reference model: word i of the frame lands at address i, one cycle after
  // its last byte; checksum is the XOR of every byte after SOF.
  task automatic send_frame(input logic [15:0] len, input bit bad, input bit rgap);
    logic [7:0]  x;
    logic [7:0]  b;
    logic [31:0] w;
    int          hs;
    x = 8'd0;
    send_byte(8'hA5, rgap, hs);
    chk("sof_accept", {busy, done, err, cpu_rst_n, cpu_en}, {1'b1, 1'b0, 2'd0, 1'b0, 1'b0});
    send_byte(len[15:8], rgap, hs);
    x ^= len[15:8];
    send_byte(len[7:0], rgap, hs);
    x ^= len[7:0];
    if (int'(len) > DEPTH) begin
      chk("len_err", {err, busy, cpu_rst_n, cpu_en}, {2'd1, 1'b0, 1'b0, 1'b0});
      return;
    end
    for (int i = 0; i < int'(len); i++) begin
      w = words[i];
      for (int j = 0; j < 4; j++) begin
        b = w[31 - 8*j -: 8];
        send_byte(b, rgap, hs);
        x ^= b;
        if (j == 3) exp_q.push_back({24'(hs), 16'(i), w});
      end
    end
    send_byte(bad ? ~x : x, rgap, hs);
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_wr_count"}, 96'(got_q.size()), 96'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  // Called right after the CSUM handshake of a good frame.
  task automatic check_run(input string tag);
    chk({tag, "_run0"}, {cpu_rst_n, cpu_en, in_ready, busy, err}, {1'b1, 1'b0, 1'b0, 1'b0, 2'd0});
    @(posedge clk);
    #1;
    chk({tag, "_run1"}, {cpu_rst_n, cpu_en}, {1'b1, 1'b1});
  endtask

  task automatic do_halt(input string tag);
    @(negedge clk);
    cpu_halt = 1'b1;
    @(posedge clk);
    #1;
    cpu_halt = 1'b0;
    chk({tag, "_halt"}, {cpu_en, done, cpu_rst_n, in_ready}, {1'b0, 1'b1, 1'b1, 1'b1});
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  localparam logic [49:0] RESET_VEC = {1'b1, 1'b0, 10'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0};

  initial begin
    int hs;
    int n;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    cpu_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, cpu_en, busy, done, err}, RESET_VEC);
    rst = 1'b0;

    // halt outside RUN is ignored
    cpu_halt = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cpu_halt = 1'b0;
    chk("halt_idle", {done, cpu_en, cpu_rst_n, busy}, 4'b0000);

    // garbage before SOF is dropped
    send_byte(8'h00, 0, hs);
    send_byte(8'hFF, 0, hs);
    send_byte(8'h5A, 0, hs);
    chk("garbage", {busy, err, 32'(got_q.size())}, {1'b0, 2'd0, 32'd0});

    // fixed test-plan frame
    words.delete();
    words.push_back(32'h12345678);
    words.push_back(32'hDEADBEEF);
    send_frame(16'd2, 0, 0);
    check_writes("fixA");
    check_run("fixA");
    // bytes offered during RUN are refused
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hA5;
      chk("run_ready", 96'(in_ready), 96'd0);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("run_ignore", {cpu_en, cpu_rst_n, busy, 32'(got_q.size())}, {1'b1, 1'b1, 1'b0, 32'd0});
    do_halt("fixA");

    // same frame, corrupted checksum
    send_frame(16'd2, 1, 0);
    check_writes("badcs");
    chk("badcs_err", {err, cpu_rst_n, cpu_en, in_ready, busy}, {2'd2, 1'b0, 1'b0, 1'b1, 1'b0});
    repeat (3) @(posedge clk);
    #1;
    chk("badcs_hold", {err, cpu_en, done}, {2'd2, 1'b0, 1'b0});

    // random frame with gaps and SOF-valued data, recovering from ERR
    n = $urandom_range(2, 6);
    fill_words(n);
    words[0] = 32'hA5A5A5A5;
    send_frame(16'(n), 0, 1);
    check_writes("rand");
    check_run("rand");
    do_halt("rand");

    // oversize lengths
    send_frame(16'hFFFF, 0, 0);
    send_byte(8'h00, 0, hs);
    send_byte(8'h11, 0, hs);
    chk("ovf_hold", {err, cpu_rst_n, busy, 32'(got_q.size())}, {2'd1, 1'b0, 1'b0, 32'd0});
    send_frame(16'(DEPTH + 1), 0, 0);
    chk("ovf1_nowr", 96'(got_q.size()), 96'd0);

    // full-capacity frame: last address DEPTH-1
    fill_words(DEPTH);
    send_frame(16'(DEPTH), 0, 0);
    check_writes("full");
    check_run("full");
    do_halt("full");

    // zero-length frame
    words.delete();
    send_frame(16'd0, 0, 0);
    check_writes("zero");
    check_run("zero");
    do_halt("zero");

    // reset after the 6th data byte
    fill_words(3);
    send_byte(8'hA5, 1, hs);
    send_byte(8'h00, 1, hs);
    send_byte(8'h03, 1, hs);
    for (int k = 0; k < 6; k++) begin
      send_byte(words[k / 4][31 - 8*(k % 4) -: 8], 1, hs);
      if (k == 3) exp_q.push_back({24'(hs), 16'd0, words[0]});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst", {in_ready, imem_we, imem_addr, imem_wdata, cpu_rst_n, cpu_en, busy, done, err}, RESET_VEC);
    repeat (10) @(posedge clk);
    #1;
    check_writes("midrst");

    // recovery after reset
    fill_words(1);
    send_frame(16'd1, 0, 1);
    check_writes("recov");
    check_run("recov");
    do_halt("recov");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
